// File: rtl/dc_timing_gen.sv
// Display-controller video timing generator: fixed raster timing with prefetching ready/valid pixel source.
// Optional build macro DC_TEST_PATTERN_EN adds a frame-latched pattern_sel input and an internal test pattern.
module dc_timing_gen #(
    parameter int H_ACTIVE = 16,
    parameter int H_SYNC   = 5,
    parameter int H_BP     = 4,
    parameter int H_FP     = 3,
    parameter int V_ACTIVE = 4,
    parameter int V_BLANK  = 2,
    parameter int V_SYNC   = 1
) (
    input  logic        dc_clk,
    input  logic        dc_rst,
    input  logic        en,
    input  logic [23:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [23:0] pixel_data,
    output logic        data_valid,
    output logic        hsync,
    output logic        vsync,
    output logic        underflow,
    input  logic        err_clr
`ifdef DC_TEST_PATTERN_EN
    ,
    input  logic        pattern_sel
`endif
);

    localparam logic [15:0] H_TOT = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [15:0] V_TOT = 16'(V_ACTIVE + V_BLANK);
    localparam logic [15:0] H_DS  = 16'(H_SYNC + H_BP);
    localparam logic [15:0] H_DE  = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] H_SW  = 16'(H_SYNC);
    localparam logic [15:0] V_SW  = 16'(V_SYNC);
    localparam logic [15:0] V_ACT = 16'(V_ACTIVE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nx;
    logic [15:0] h_cnt, v_cnt, nh, nv;
    logic        line_end, frame_end, run_nx, act_nx, pf, fill;

    function automatic logic active(input logic [15:0] h, input logic [15:0] v);
        return (v < V_ACT) && (h >= H_DS) && (h < H_DE);
    endfunction

    assign line_end  = (h_cnt == H_TOT - 16'd1);
    assign frame_end = line_end && (v_cnt == V_TOT - 16'd1);

    // State register
    always_ff @(posedge dc_clk or posedge dc_rst) begin
        if (dc_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: frames are never truncated, en only matters at frame boundaries
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (frame_end && !en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Position that will be on the outputs after the next edge
    always_comb begin
        nh = h_cnt + 16'd1;
        nv = v_cnt;
        if (state == IDLE || frame_end) begin
            nh = '0;
            nv = '0;
        end else if (line_end) begin
            nh = '0;
            nv = v_cnt + 16'd1;
        end
    end

    assign run_nx = (state_nx == RUN);
    assign act_nx = active(nh, nv);
    assign pf     = (state == RUN) && act_nx;

`ifdef DC_TEST_PATTERN_EN
    logic       pat_q;
    logic [7:0] frame_cnt;
    logic [7:0] pix_off;
    assign pix_off = nh[7:0] - H_DS[7:0];

    always_ff @(posedge dc_clk or posedge dc_rst) begin
        if (dc_rst) begin
            pat_q     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (run_nx && nh == '0 && nv == '0 && (state == IDLE || frame_end))
                pat_q <= pattern_sel;
            if (state == RUN && frame_end)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

    // Output decode: ready is a prefetch, a function of FSM and counters only
    always_comb begin
        src_ready = pf;
`ifdef DC_TEST_PATTERN_EN
        if (pat_q) src_ready = 1'b0;
`endif
    end

    assign fill = src_ready && !src_valid;

    always_ff @(posedge dc_clk or posedge dc_rst) begin
        if (dc_rst) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            data_valid <= 1'b0;
            pixel_data <= '0;
            underflow  <= 1'b0;
        end else begin
            h_cnt      <= nh;
            v_cnt      <= nv;
            hsync      <= run_nx && (nh < H_SW);
            vsync      <= run_nx && (nv < V_SW);
            data_valid <= run_nx && act_nx;
            if (src_ready)
                pixel_data <= src_valid ? src_data : 24'h000000;
`ifdef DC_TEST_PATTERN_EN
            else if (pf && pat_q)
                pixel_data <= {pix_off, nv[7:0], frame_cnt};
`endif
            underflow <= fill || (underflow && !err_clr);
        end
    end

endmodule

// File: tb/tb_dc_timing_gen.sv
// Directed bench for dc_timing_gen (default build): raster timing, prefetch handshake, underflow, en and reset.
module tb_dc_timing_gen;

    logic        dc_clk = 1'b0;
    logic        dc_rst = 1'b1;
    logic        en = 1'b0;
    logic [23:0] src_data;
    logic        src_valid = 1'b1;
    logic        src_ready;
    logic [23:0] pixel_data;
    logic        data_valid, hsync, vsync, underflow;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [23:0] src_cnt;

    dc_timing_gen dut (
        .dc_clk(dc_clk), .dc_rst(dc_rst), .en(en),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .pixel_data(pixel_data), .data_valid(data_valid),
        .hsync(hsync), .vsync(vsync), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 dc_clk = ~dc_clk;

    // Upstream source: incrementing data, advances on each transfer
    always @(posedge dc_clk or posedge dc_rst) begin
        if (dc_rst) src_cnt <= '0;
        else if (src_ready && src_valid) src_cnt <= src_cnt + 24'd1;
    end
    assign src_data = src_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge dc_clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hs"}, 32'(hsync), 0);
        chk({tag, "_vs"}, 32'(vsync), 0);
        chk({tag, "_dv"}, 32'(data_valid), 0);
        chk({tag, "_rdy"}, 32'(src_ready), 0);
    endtask

    // Call right after reset release (cycle T) with en=1 and src always valid
    task automatic first_line();
        tick(1);  chk("t1_hs", 32'(hsync), 1); chk("t1_vs", 32'(vsync), 1); chk("t1_dv", 32'(data_valid), 0);
        tick(4);  chk("t5_hs", 32'(hsync), 1);
        tick(1);  chk("t6_hs", 32'(hsync), 0); chk("t6_vs", 32'(vsync), 1);
        tick(3);  chk("t9_dv", 32'(data_valid), 0);
        tick(1);  chk("t10_dv", 32'(data_valid), 1); chk("t10_pix", 32'(pixel_data), 0);
        tick(15); chk("t25_dv", 32'(data_valid), 1); chk("t25_pix", 32'(pixel_data), 15);
        tick(1);  chk("t26_dv", 32'(data_valid), 0); chk("t26_hold", 32'(pixel_data), 15);
        tick(3);  chk("t29_hs", 32'(hsync), 1); chk("t29_vs", 32'(vsync), 0);
    endtask

    task automatic do_reset();
        dc_rst = 1'b1;
        tick(2);
        chk_zero("rst");
        chk("rst_pix", 32'(pixel_data), 0);
        chk("rst_uf", 32'(underflow), 0);
        dc_rst = 1'b0;
    endtask

    initial begin
        int n_dv, n_vs, rdy_err, pix_err, s0;
        logic prev_rdy;
        logic [23:0] exp_pix;

        // Scenario: first frame timing then a free-running frame
        en = 1'b1;
        do_reset();
        first_line();                       // now at T+29
        tick(139);                          // T+168, last cycle of frame 1
        prev_rdy = src_ready;
        tick(1);                            // T+169, frame 2 start
        chk("f2_hs", 32'(hsync), 1);
        chk("f2_vs", 32'(vsync), 1);
        n_dv = 0; n_vs = 0; rdy_err = 0; pix_err = 0;
        exp_pix = 24'd64;
        s0 = int'(src_cnt);
        for (int i = 0; i < 168; i++) begin
            if (data_valid) begin
                n_dv++;
                if (pixel_data !== exp_pix) pix_err++;
                exp_pix = exp_pix + 24'd1;
            end
            if (vsync) n_vs++;
            if (prev_rdy !== data_valid) rdy_err++;
            prev_rdy = src_ready;
            tick(1);
        end
        chk("f2_dv_cnt", 32'(n_dv), 64);
        chk("f2_vs_cnt", 32'(n_vs), 28);
        chk("f2_xfer", 32'(int'(src_cnt) - s0), 64);
        chk("f2_rdy_err", 32'(rdy_err), 0);
        chk("f2_pix_err", 32'(pix_err), 0);
        chk("f3_hs", 32'(hsync), 1);
        chk("f3_vs", 32'(vsync), 1);
        chk("f2_uf", 32'(underflow), 0);

        // Scenario: asynchronous reset mid active pixel
        tick(12);
        chk("mid_dv", 32'(data_valid), 1);
        #3 dc_rst = 1'b1;
        #1;
        chk_zero("arst");
        chk("arst_pix", 32'(pixel_data), 0);
        tick(1);
        dc_rst = 1'b0;
        first_line();

        // Scenario: underflow on 6th pixel of line 0, clear, then set-wins
        do_reset();
        tick(14);
        chk("uf_rdy", 32'(src_ready), 1);
        src_valid = 1'b0;
        tick(1);
        chk("uf_dv", 32'(data_valid), 1);
        chk("uf_pix", 32'(pixel_data), 0);
        chk("uf_set", 32'(underflow), 1);
        src_valid = 1'b1;
        tick(1);
        chk("uf_next", 32'(pixel_data), 5);
        tick(20);                           // T+36
        chk("uf_hold", 32'(underflow), 1);
        err_clr = 1'b1;
        tick(1);                            // T+37
        err_clr = 1'b0;
        chk("uf_clr", 32'(underflow), 0);
        chk("uf_rdy2", 32'(src_ready), 1);
        src_valid = 1'b0;
        err_clr = 1'b1;
        tick(1);                            // T+38
        chk("uf_setwin", 32'(underflow), 1);
        chk("uf_dv2", 32'(data_valid), 1);
        src_valid = 1'b1;
        err_clr = 1'b0;

        // Scenario: en dropped in line 1, frame completes then IDLE
        do_reset();
        tick(30);
        en = 1'b0;
        tick(111);                          // T+141, line 5 h=0
        chk("en_l5_hs", 32'(hsync), 1);
        chk("en_l5_vs", 32'(vsync), 0);
        tick(27);                           // T+168
        chk("en_last_hs", 32'(hsync), 0);
        tick(1);                            // T+169
        chk_zero("idle");
        chk("idle_pix", 32'(pixel_data), 32'd63);
        tick(5);
        chk_zero("idle2");
        en = 1'b1;
        tick(1);
        chk("re_hs", 32'(hsync), 1);
        chk("re_vs", 32'(vsync), 1);
        tick(9);
        chk("re_dv", 32'(data_valid), 1);
        chk("re_pix", 32'(pixel_data), 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
